ms_fifo_ahbl: RTL and testbench

MS_FIFO_AHBL -- requirements
Module: ms_fifo_ahbl

---
 rtl/ms_fifo_ahbl_pkg.sv | 28 ++
 rtl/ms_fifo_sync.sv | 74 +++++++
 rtl/ms_fifo_ahbl.sv | 141 ++++++++++++++
 tb/tb_ms_fifo_ahbl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_fifo_ahbl_pkg.sv
// Shared AHB-Lite slave definitions for the FIFO peripheral:
// register offsets, STATUS/CTRL bit positions and the latched address phase.
package ms_fifo_ahbl_pkg;

    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_CTRL   = 8'h08;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_IRQ       = 3;
    localparam int ST_LEVEL_LSB = 8;

    localparam int CT_EN         = 0;
    localparam int CT_FLUSH      = 1;
    localparam int CT_OVF_CLR    = 2;
    localparam int CT_THRESH_LSB = 8;

    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic       sel;
        logic       write;
        logic [7:0] addr;
    } aphase_t;

endpackage

// File: rtl/ms_fifo_sync.sv
// Synchronous FIFO: storage, wrapping pointers and a saturating level.
// Storage is not reset; its contents only matter while non-empty.
module ms_fifo_sync #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next pointers and level; flush wins over any pop in the same cycle.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/ms_fifo_ahbl.sv
// AHB-Lite slave front end for a stream FIFO: bus decode, CTRL/STATUS,
// back-pressure stall on full, and a space-available interrupt.
module ms_fifo_ahbl
    import ms_fifo_ahbl_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        IRQ
);

    aphase_t     aph_q, aph_d;
    logic        en_q, en_d;
    logic [7:0]  thresh_q, thresh_d;
    logic        ovf_q, ovf_d;

    logic [31:0] fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;

    logic        dp_wr;
    logic        data_wr;
    logic        ctrl_wr;
    logic        stall;
    logic        push;
    logic        pop;
    logic        flush;
    logic [31:0] status;
    logic [31:0] ctrl_rd;
    logic        unused_ok;

    assign unused_ok = ^{HSIZE, HADDR[31:8], HTRANS[0]};

    assign dp_wr   = aph_q.sel & aph_q.write;
    assign data_wr = dp_wr & (aph_q.addr == REG_DATA);
    assign ctrl_wr = dp_wr & (aph_q.addr == REG_CTRL);

    // Stall only on full; OUT_READY affects it one cycle later via FULL.
    assign stall = data_wr & en_q & fifo_full;
    assign push  = data_wr & en_q & ~fifo_full;
    assign pop   = ~fifo_empty & OUT_READY;
    assign flush = ctrl_wr & HWDATA[CT_FLUSH];

    assign HREADYOUT = ~stall;
    assign OUT_VALID = ~fifo_empty;
    assign OUT_DATA  = fifo_rdata;
    assign IRQ       = en_q & (16'(fifo_level) <= {8'h00, thresh_q});

    // Capture the address phase whenever the bus advances.
    always_comb begin
        aph_d = aph_q;
        if (HREADY) begin
            aph_d.sel   = HSEL & HTRANS[1];
            aph_d.write = HWRITE;
            aph_d.addr  = HADDR[7:0];
        end
    end

    // CTRL fields and the sticky overflow flag.
    always_comb begin
        en_d     = en_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        if (ctrl_wr) begin
            en_d     = HWDATA[CT_EN];
            thresh_d = HWDATA[CT_THRESH_LSB +: 8];
            if (HWDATA[CT_OVF_CLR]) ovf_d = 1'b0;
        end
        if (data_wr && !en_q) ovf_d = 1'b1;
    end

    // Bus-side state registers.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            aph_q    <= '0;
            en_q     <= 1'b0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            aph_q    <= aph_d;
            en_q     <= en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
        end
    end

    // STATUS and CTRL read images; FLUSH and OVF_CLR always read 0.
    always_comb begin
        status                         = '0;
        status[ST_EMPTY]               = fifo_empty;
        status[ST_FULL]                = fifo_full;
        status[ST_OVF]                 = ovf_q;
        status[ST_IRQ]                 = IRQ;
        status[ST_LEVEL_LSB +: AW+1]   = fifo_level;
        ctrl_rd                        = '0;
        ctrl_rd[CT_EN]                 = en_q;
        ctrl_rd[CT_THRESH_LSB +: 8]    = thresh_q;
    end

    // Zero-wait-state read mux driven by the latched address.
    always_comb begin
        case (aph_q.addr)
            REG_DATA:   HRDATA = fifo_rdata;
            REG_STATUS: HRDATA = status;
            REG_CTRL:   HRDATA = ctrl_rd;
            default:    HRDATA = UNMAPPED_RDATA;
        endcase
    end

    ms_fifo_sync #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .flush (flush),
        .push  (push),
        .wdata (HWDATA),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_ms_fifo_ahbl.sv
// Bench for ms_fifo_ahbl: queue-based reference model checked every cycle,
// directed scenarios plus a randomized bus/stream phase.
module tb_ms_fifo_ahbl;

    localparam int DEPTH = 16;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        IRQ;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ms_fifo_ahbl #(.DEPTH(DEPTH)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .IRQ       (IRQ)
    );

    logic [31:0] mq [$];
    bit          m_en, m_ovf;
    logic [7:0]  m_th;
    bit          dp_v, dp_w;
    logic [7:0]  dp_a;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata, last_pop;
    logic        last_hro;
    bit          last_stall;
    bit          seen_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_irq();
        return m_en && (mq.size() <= int'(m_th));
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s    = 32'(mq.size()) << 8;
        s[0] = (mq.size() == 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_irq();
        return s;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_en  = 0;
        m_th  = '0;
        m_ovf = 0;
        dp_v  = 0;
        dp_w  = 0;
        dp_a  = '0;
    endtask

    task automatic cyc();
        bit          stall, pop, push, flush, dataw, ctrlw;
        logic [31:0] exp;
        @(negedge HCLK);
        dataw = dp_v && dp_w && (dp_a == 8'h00);
        ctrlw = dp_v && dp_w && (dp_a == 8'h08);
        stall = dataw && m_en && (mq.size() == DEPTH);
        chk("hreadyout", 32'(HREADYOUT), 32'(!stall));
        chk("out_valid", 32'(OUT_VALID), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("out_data", OUT_DATA, mq[0]);
        chk("irq", 32'(IRQ), 32'(m_irq()));
        if (dp_v && !dp_w && !(dp_a == 8'h00 && mq.size() == 0)) begin
            case (dp_a)
                8'h00:   exp = mq[0];
                8'h04:   exp = m_status();
                8'h08:   exp = {16'h0, m_th, 7'h0, m_en};
                default: exp = 32'hDEADBEEF;
            endcase
            chk("hrdata", HRDATA, exp);
        end
        last_rdata = HRDATA;
        last_hro   = HREADYOUT;
        last_stall = stall;
        pop   = OUT_READY && (mq.size() > 0) && HRESETn;
        push  = dataw && m_en && (mq.size() < DEPTH);
        flush = ctrlw && HWDATA[1];
        if (pop) begin
            last_pop = mq[0];
            if (mq[0] == 32'hBAD0BAD0) seen_bad = 1;
        end
        @(posedge HCLK);
        if (!HRESETn) begin
            m_reset();
        end else begin
            if (flush) mq.delete();
            else begin
                if (pop)  void'(mq.pop_front());
                if (push) mq.push_back(HWDATA);
            end
            if (ctrlw) begin
                m_en = HWDATA[0];
                m_th = HWDATA[15:8];
                if (HWDATA[2]) m_ovf = 0;
            end
            if (dataw && !m_en) m_ovf = 1;
            if (!stall) begin
                dp_v = HSEL && HTRANS[1];
                dp_w = HWRITE;
                dp_a = HADDR[7:0];
            end
        end
        #1;
    endtask

    task automatic aph(input bit w, input logic [7:0] a);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HSIZE  = 3'b010;
        HADDR  = {24'($urandom), a};
    endtask

    task automatic idle();
        HSEL   = 1'($urandom);
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        aph(1'b1, a);
        cyc();
        idle();
        HWDATA = d;
        cyc();
        while (last_stall && n < 64) begin
            cyc();
            n++;
        end
        if (last_stall) chk("wr_timeout", 32'(last_stall), 32'd0);
    endtask

    task automatic rd(input logic [7:0] a);
        aph(1'b0, a);
        cyc();
        idle();
        cyc();
    endtask

    task automatic burst(input int n);
        OUT_READY = 1'b0;
        aph(1'b1, 8'h00);
        cyc();
        OUT_READY = 1'b1;
        for (int i = 0; i < n; i++) begin
            HWDATA = $urandom;
            if (i == n - 1) idle();
            else aph(1'b1, 8'h00);
            cyc();
        end
        OUT_READY = 1'b0;
    endtask

    initial begin
        logic [7:0] ua;
        HRESETn   = 1'b0;
        OUT_READY = 1'b0;
        HWDATA    = '0;
        HSIZE     = 3'b010;
        idle();
        repeat (2) @(posedge HCLK);
        #1;
        m_reset();
        cyc();
        HRESETn = 1'b1;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);

        wr(8'h08, 32'h0000_0401);
        wr(8'h00, 32'hA5A5_0001);
        chk("first_valid", 32'(OUT_VALID), 32'd1);
        chk("first_data", OUT_DATA, 32'hA5A5_0001);
        chk("first_irq", 32'(IRQ), 32'd1);
        rd(8'h04);
        chk("first_level", 32'(last_rdata[15:8]), 32'd1);

        wr(8'h08, 32'h0000_0403);
        for (int i = 0; i < DEPTH; i++) wr(8'h00, 32'h100 + i);
        rd(8'h04);
        chk("full_flag", 32'(last_rdata[1]), 32'd1);
        aph(1'b1, 8'h00);
        cyc();
        idle();
        HWDATA = 32'h1234;
        cyc();
        chk("stall_a", 32'(last_hro), 32'd0);
        cyc();
        chk("stall_b", 32'(last_hro), 32'd0);
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;
        cyc();
        chk("stall_release", 32'(last_hro), 32'd1);
        rd(8'h04);
        chk("stall_level", 32'(last_rdata[15:8]), 32'd16);
        OUT_READY = 1'b1;
        repeat (DEPTH) cyc();
        OUT_READY = 1'b0;
        chk("stall_last", last_pop, 32'h1234);
        chk("drained", 32'(OUT_VALID), 32'd0);

        wr(8'h08, 32'h0000_0403);
        for (int i = 0; i < 5; i++) wr(8'h00, $urandom);
        burst(45);
        rd(8'h04);
        chk("b2b_level", 32'(last_rdata[15:8]), 32'd5);

        repeat (150) begin
            OUT_READY = 1'($urandom);
            case ($urandom_range(0, 5))
                0, 1: begin
                    if (mq.size() == DEPTH) OUT_READY = 1'b1;
                    wr(8'h00, $urandom);
                end
                2: rd(8'h04);
                3: rd(8'h00);
                4: begin
                    ua = 8'($urandom);
                    if (ua == 8'h00 || ua == 8'h04 || ua == 8'h08) ua = 8'hFC;
                    if ($urandom_range(0, 1) == 0) rd(ua);
                    else wr(ua, $urandom);
                end
                default: wr(8'h08, {16'h0, 8'($urandom_range(0, 20)), 5'h0,
                                    1'($urandom), 1'($urandom_range(0, 7) == 0),
                                    1'($urandom_range(0, 3) != 0)});
            endcase
        end

        OUT_READY = 1'b0;
        wr(8'h08, 32'h0000_0400);
        wr(8'h00, 32'h0000_00FF);
        chk("ovf_nostall", 32'(last_hro), 32'd1);
        rd(8'h04);
        chk("ovf_set", 32'(last_rdata[2]), 32'd1);
        chk("ovf_level", 32'(last_rdata[15:8]), 32'(mq.size()));
        wr(8'h08, 32'h0000_0004);
        rd(8'h04);
        chk("ovf_clr", 32'(last_rdata[2]), 32'd0);

        wr(8'h08, 32'h0000_0403);
        for (int i = 0; i < 7; i++) wr(8'h00, $urandom);
        rd(8'h04);
        chk("pre_flush_level", 32'(last_rdata[15:8]), 32'd7);
        wr(8'h08, 32'h0000_0403);
        chk("flush_valid", 32'(OUT_VALID), 32'd0);
        rd(8'h04);
        chk("flush_empty", 32'(last_rdata[0]), 32'd1);
        chk("flush_level", 32'(last_rdata[15:8]), 32'd0);
        rd(8'h08);
        chk("flush_ctrl", last_rdata, 32'h0000_0401);

        for (int i = 0; i < DEPTH; i++) wr(8'h00, 32'h200 + i);
        aph(1'b1, 8'h00);
        cyc();
        idle();
        HWDATA = 32'hBAD0BAD0;
        cyc();
        cyc();
        chk("rst_stall", 32'(last_hro), 32'd0);
        HRESETn = 1'b0;
        cyc();
        HRESETn = 1'b1;
        chk("rst_mid_hro", 32'(HREADYOUT), 32'd1);
        chk("rst_mid_valid", 32'(OUT_VALID), 32'd0);
        rd(8'h04);
        chk("rst_mid_level", 32'(last_rdata[15:8]), 32'd0);
        wr(8'h08, 32'h0000_0001);
        OUT_READY = 1'b1;
        repeat (20) cyc();
        chk("rst_no_bad", 32'(seen_bad), 32'd0);
        chk("rst_still_empty", 32'(OUT_VALID), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
